// File: rtl/dff_with_en_pkg.sv
// Shared types and constants for the enabled register bank.
// Priority classes name the three edge outcomes (reset, load, hold) for the embedded checks.
package dff_with_en_pkg;

  localparam int DFF_DEFAULT_WIDTH = 1;

  typedef logic rst_n_t;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } prio_e;

  function automatic prio_e prio_of(input rst_n_t reset, input logic en);
    if (!reset)  return RST;
    else if (en) return LOAD;
    else         return HOLD;
  endfunction

endpackage

// File: rtl/dff_with_en_cell.sv
// One enabled flop with synchronous active-low reset; 1-cycle latency, no backpressure.
// Hold is a recirculating mux rather than a gated clock.
module dff_with_en_cell
  import dff_with_en_pkg::*;
(
  input  logic   clk,
  input  rst_n_t reset,
  input  logic   d_i,
  input  logic   en_i,
  input  logic   rst_val_i,
  output logic   q_o
);

  always_ff @(posedge clk) begin
    if (!reset) q_o <= rst_val_i;
    else        q_o <= en_i ? d_i : q_o;
  end

endmodule

// File: rtl/dff_with_en.sv
// WIDTH-bit enabled register bank, synchronous active-low reset, 1-cycle latency, no backpressure.
// Optional q_chg_o change flag is built only with DFF_WITH_EN_CHG_FLAG_EN defined.
module dff_with_en
  import dff_with_en_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  rst_n_t           reset,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
`ifdef DFF_WITH_EN_CHG_FLAG_EN
  output logic             q_chg_o,
`endif
  output logic [WIDTH-1:0] q_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dff_with_en_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .d_i       (d_i[i]),
      .en_i      (en_i),
      .rst_val_i (RESET_VAL[i]),
      .q_o       (q_o[i])
    );
  end

`ifdef DFF_WITH_EN_CHG_FLAG_EN
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q_o;
    if (!reset)    q_next = RESET_VAL;
    else if (en_i) q_next = d_i;
  end

  // Not reset: a reset that moves q_o off a non-reset value must still flag.
  always_ff @(posedge clk) begin
    q_chg_o <= (q_next != q_o);
  end
`endif

`ifndef SYNTHESIS
  prio_e prio;
  assign prio = prio_of(reset, en_i);

  a_rst:  assert property (@(posedge clk) prio == RST  |=> q_o == RESET_VAL);
  a_load: assert property (@(posedge clk) prio == LOAD |=> q_o == $past(d_i));
  a_hold: assert property (@(posedge clk) prio == HOLD |=> $stable(q_o));
`endif

endmodule

// File: tb/tb_dff_with_en.sv
module tb_dff_with_en;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;
`ifdef DFF_WITH_EN_CHG_FLAG_EN
  logic       chg1;
  logic       chg8;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dff_with_en u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .d_i     (d1),
    .en_i    (en),
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    .q_chg_o (chg1),
`endif
    .q_o     (q1)
  );

  dff_with_en #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .clk     (clk),
    .reset   (reset),
    .d_i     (d8),
    .en_i    (en),
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    .q_chg_o (chg8),
`endif
    .q_o     (q8)
  );

  // Model: every edge is logged; the output after edge n is decided by the
  // most recent edge that either reset or loaded.
  typedef struct {
    logic       rst_n;
    logic       en;
    logic       d1;
    logic [7:0] d8;
  } edge_t;

  edge_t hist[$];

  always @(posedge clk) hist.push_back('{reset, en, d1, d8});

  function automatic bit model_q(input int upto, input bit wide, output logic [7:0] v);
    v = 8'h00;
    for (int k = upto - 1; k >= 0; k--) begin
      if (hist[k].rst_n == 1'b0) begin
        v = wide ? 8'hA5 : 8'h00;
        return 1'b1;
      end
      if (hist[k].en == 1'b1) begin
        v = wide ? hist[k].d8 : {7'h0, hist[k].d1};
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
      if (fails > 10) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] a, b;
    int n;
    n = hist.size();
    if (model_q(n, 1'b0, a)) check("model_q1", {7'h0, q1}, a);
    if (model_q(n, 1'b1, a)) check("model_q8", q8, a);
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    if (n > 1 && model_q(n, 1'b1, a) && model_q(n - 1, 1'b1, b))
      check("model_chg8", {7'h0, chg8}, {7'h0, a != b});
    if (n > 1 && model_q(n, 1'b0, a) && model_q(n - 1, 1'b0, b))
      check("model_chg1", {7'h0, chg1}, {7'h0, a != b});
`endif
  end

  // Called at a falling edge: drive 1 ns later, return at the next falling edge.
  task automatic step(input logic r, input logic e, input logic a, input logic [7:0] b);
    #1;
    reset = r; en = e; d1 = a; d8 = b;
    @(negedge clk);
  endtask

  logic [19:0] data;

  initial begin
    data  = 20'h07C1F;
    reset = 1'b0; en = 1'b1; d1 = 1'b1; d8 = 8'hFF;

    // T1: reset dominates for three edges
    @(negedge clk);
    check("t1_q1_first", {7'h0, q1}, 8'h00);
    check("t1_q8_first", q8, 8'hA5);
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    check("t1_q1_held", {7'h0, q1}, 8'h00);

    // T2: enable low, output must not move
    for (int i = 0; i <= 8; i++) begin
      step(1'b1, 1'b0, data[i], 8'(i * 17));
      check("t2_q1_hold", {7'h0, q1}, 8'h00);
      check("t2_q8_hold", q8, 8'hA5);
    end

    // T3: loading pattern bits; bit 9 is 0, bits 10..13 are 1
    for (int i = 9; i <= 13; i++) begin
      step(1'b1, 1'b1, data[i], 8'(i * 3 + 1));
      check("t3_q1_load", {7'h0, q1}, {7'h0, data[i]});
      check("t3_q8_load", q8, 8'(i * 3 + 1));
    end
    check("t3_q1_lit", {7'h0, q1}, 8'h01);

    // T4: reset wins over enable
    for (int i = 14; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'h5A);
      check("t4_q1_rst", {7'h0, q1}, 8'h00);
      check("t4_q8_rst", q8, 8'hA5);
    end

    // T5: recovery with no dead cycle, then hold
    step(1'b1, 1'b1, 1'b1, 8'h77);
    check("t5_q1_recover", {7'h0, q1}, 8'h01);
    check("t5_q8_recover", q8, 8'h77);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("t5_q1_hold", {7'h0, q1}, 8'h01);
    check("t5_q8_hold", q8, 8'h77);

    // T6: change flag on the 8-bit bank
    step(1'b0, 1'b1, 1'b0, 8'h3C);
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    check("t6_chg_rst_moved", {7'h0, chg8}, 8'h01);
`endif
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    check("t6_q8_rst", q8, 8'hA5);
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    check("t6_chg_rst_same", {7'h0, chg8}, 8'h00);
`endif
    step(1'b1, 1'b1, 1'b0, 8'h3C);
    check("t6_q8_load", q8, 8'h3C);
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    check("t6_chg_load", {7'h0, chg8}, 8'h01);
`endif
    step(1'b1, 1'b1, 1'b0, 8'h3C);
    check("t6_q8_reload", q8, 8'h3C);
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    check("t6_chg_reload", {7'h0, chg8}, 8'h00);
`endif
    step(1'b1, 1'b0, 1'b1, 8'hC3);
    check("t6_q8_hold", q8, 8'h3C);
`ifdef DFF_WITH_EN_CHG_FLAG_EN
    check("t6_chg_hold", {7'h0, chg8}, 8'h00);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
